// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store issue queue.
// Optional same-cycle CDB bypass: LSU_ISSUE_QUEUE_CDB_BYPASS_EN.
package lsu_pkg;

    localparam logic [1:0] MSIZE_B = 2'd0;
    localparam logic [1:0] MSIZE_H = 2'd1;
    localparam logic [1:0] MSIZE_W = 2'd2;

    typedef struct packed {
        logic        wmem;
        logic        msigned;
        logic [1:0]  msize;
        logic [31:0] imm;
    } iq_op_t;

    typedef struct packed {
        logic        wmem;
        logic        msigned;
        logic [1:0]  msize;
        logic [31:0] vaddr;
        logic [31:0] wdata;
        logic [3:0]  rmask;
        logic [3:0]  strb;
        logic        misalign;
    } lsu_req_t;

    function automatic logic [3:0] byte_mask(
        input logic [1:0] msize,
        input logic [1:0] addr
    );
        case (msize)
            MSIZE_B: byte_mask = 4'b0001 << addr;
            MSIZE_H: byte_mask = 4'b0011 << {addr[1], 1'b0};
            MSIZE_W: byte_mask = 4'b1111;
            default: byte_mask = 4'b0000;
        endcase
    endfunction

    function automatic logic is_misaligned(
        input logic [1:0] msize,
        input logic [1:0] addr
    );
        is_misaligned = ((msize == MSIZE_H) && addr[0])
                     || ((msize == MSIZE_W) && (addr != 2'b00));
    endfunction

    function automatic lsu_req_t build_req(
        input iq_op_t      op,
        input logic [31:0] base,
        input logic [31:0] sdata
    );
        lsu_req_t    r;
        logic [31:0] va;
        logic [3:0]  m;
        va         = base + op.imm;
        m          = byte_mask(op.msize, va[1:0]);
        r.wmem     = op.wmem;
        r.msigned  = op.msigned;
        r.msize    = op.msize;
        r.vaddr    = va;
        r.wdata    = op.wmem ? sdata : 32'd0;
        r.rmask    = op.wmem ? 4'd0 : m;
        r.strb     = op.wmem ? m : 4'd0;
        r.misalign = is_misaligned(op.msize, va[1:0]);
        build_req  = r;
    endfunction

endpackage

// File: rtl/lsu_iq_slot.sv
// One issue-queue entry: op fields, two operands and CDB wakeup.
// LSU_ISSUE_QUEUE_CDB_BYPASS_EN lets a live CDB match count as ready.
module lsu_iq_slot
    import lsu_pkg::*;
#(
    parameter int CDB_COUNT = 2,
    parameter int ROB_ID_W  = 6
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               flush,
    input  logic                               init,
    input  iq_op_t                             init_op,
    input  logic [ROB_ID_W-1:0]                init_rob_id,
    input  logic [1:0]                         init_src_valid,
    input  logic [1:0][ROB_ID_W-1:0]           init_src_tag,
    input  logic [1:0][31:0]                   init_src_data,
    input  logic                               pop,
    input  logic [CDB_COUNT-1:0]               cdb_valid,
    input  logic [CDB_COUNT-1:0][ROB_ID_W-1:0] cdb_rob_id,
    input  logic [CDB_COUNT-1:0][31:0]         cdb_data,
    output logic                               ready,
    output iq_op_t                             op,
    output logic [ROB_ID_W-1:0]                rob_id,
    output logic [1:0][31:0]                   src_data
);

    logic                     valid;
    logic [1:0]               src_valid;
    logic [1:0][ROB_ID_W-1:0] src_tag;
    logic [1:0][31:0]         src_q;
    logic [1:0]               hit;
    logic [1:0][31:0]         hit_data;
    logic [1:0]               init_hit;
    logic [1:0][31:0]         init_hit_data;
    logic [1:0]               eff_valid;

    // Descending scan so the lowest matching CDB port wins.
    always_comb begin
        hit           = '0;
        hit_data      = '0;
        init_hit      = '0;
        init_hit_data = '0;
        for (int k = 0; k < 2; k++) begin
            for (int c = CDB_COUNT - 1; c >= 0; c--) begin
                if (cdb_valid[c] && (cdb_rob_id[c] == src_tag[k])) begin
                    hit[k]      = 1'b1;
                    hit_data[k] = cdb_data[c];
                end
                if (cdb_valid[c] && (cdb_rob_id[c] == init_src_tag[k])) begin
                    init_hit[k]      = 1'b1;
                    init_hit_data[k] = cdb_data[c];
                end
            end
        end
    end

    always_comb begin
        for (int k = 0; k < 2; k++) begin
`ifdef LSU_ISSUE_QUEUE_CDB_BYPASS_EN
            eff_valid[k] = src_valid[k] | hit[k];
            src_data[k]  = src_valid[k] ? src_q[k] : hit_data[k];
`else
            eff_valid[k] = src_valid[k];
            src_data[k]  = src_q[k];
`endif
        end
        ready = valid && eff_valid[1] && (!op.wmem || eff_valid[0]);
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            valid     <= 1'b0;
            src_valid <= '0;
            src_tag   <= '0;
            src_q     <= '0;
            op        <= '0;
            rob_id    <= '0;
        end else if (init) begin
            valid  <= 1'b1;
            op     <= init_op;
            rob_id <= init_rob_id;
            for (int k = 0; k < 2; k++) begin
                src_tag[k]   <= init_src_tag[k];
                src_valid[k] <= init_src_valid[k] | init_hit[k];
                src_q[k]     <= init_src_valid[k] ? init_src_data[k]
                                                  : init_hit_data[k];
            end
        end else begin
            if (pop) begin
                valid <= 1'b0;
            end
            for (int k = 0; k < 2; k++) begin
                if (valid && !src_valid[k] && hit[k]) begin
                    src_valid[k] <= 1'b1;
                    src_q[k]     <= hit_data[k];
                end
            end
        end
    end

endmodule

// File: rtl/lsu_issue_queue.sv
// In-order LSU issue queue: multi-lane dispatch, CDB wakeup, head issue.
// Define LSU_ISSUE_QUEUE_CDB_BYPASS_EN for same-cycle CDB head bypass.
module lsu_issue_queue
    import lsu_pkg::*;
#(
    parameter int IQ_SIZE    = 8,
    parameter int DISP_WIDTH = 2,
    parameter int CDB_COUNT  = 2,
    parameter int ROB_ID_W   = 6
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  flush,
    input  logic [DISP_WIDTH-1:0]                 disp_valid_i,
    output logic                                  disp_ready_o,
    input  logic [DISP_WIDTH-1:0]                 disp_wmem_i,
    input  logic [DISP_WIDTH-1:0]                 disp_msigned_i,
    input  logic [DISP_WIDTH-1:0][1:0]            disp_msize_i,
    input  logic [DISP_WIDTH-1:0][31:0]           disp_imm_i,
    input  logic [DISP_WIDTH-1:0][ROB_ID_W-1:0]   disp_rob_id_i,
    input  logic [DISP_WIDTH-1:0][1:0]            disp_src_valid_i,
    input  logic [DISP_WIDTH-1:0][1:0][ROB_ID_W-1:0] disp_src_tag_i,
    input  logic [DISP_WIDTH-1:0][1:0][31:0]      disp_src_data_i,
    input  logic [CDB_COUNT-1:0]                  cdb_valid_i,
    input  logic [CDB_COUNT-1:0][ROB_ID_W-1:0]    cdb_rob_id_i,
    input  logic [CDB_COUNT-1:0][31:0]            cdb_data_i,
    output logic                                  req_valid_o,
    input  logic                                  req_ready_i,
    output logic [ROB_ID_W-1:0]                   req_rob_id_o,
    output logic                                  req_wmem_o,
    output logic                                  req_msigned_o,
    output logic [1:0]                            req_msize_o,
    output logic [31:0]                           req_vaddr_o,
    output logic [31:0]                           req_wdata_o,
    output logic [3:0]                            req_rmask_o,
    output logic [3:0]                            req_strb_o,
    output logic                                  req_misalign_o,
    output logic [$clog2(IQ_SIZE+1)-1:0]          occupancy_o
);

    localparam int IDX_W  = (IQ_SIZE > 1) ? $clog2(IQ_SIZE) : 1;
    localparam int CNT_W  = $clog2(IQ_SIZE + 1);
    localparam int LANE_W = (DISP_WIDTH > 1) ? $clog2(DISP_WIDTH) : 1;

    logic [IDX_W-1:0]          head;
    logic [IDX_W-1:0]          tail;
    logic [CNT_W-1:0]          count;
    logic [CNT_W-1:0]          count_next;
    logic [CNT_W-1:0]          push_cnt;
    logic [DISP_WIDTH-1:0]     push;
    logic [IDX_W-1:0]          pos;
    logic [IDX_W-1:0]          lane_slot [DISP_WIDTH];
    iq_op_t                    lane_op   [DISP_WIDTH];
    logic [IQ_SIZE-1:0]        slot_init;
    logic [LANE_W-1:0]         slot_lane [IQ_SIZE];
    logic [IQ_SIZE-1:0]        slot_ready;
    iq_op_t                    slot_op   [IQ_SIZE];
    logic [ROB_ID_W-1:0]       slot_rob  [IQ_SIZE];
    logic [1:0][31:0]          slot_src  [IQ_SIZE];
    logic                      pop;
    logic                      ready_next;
    int                        free;
    lsu_req_t                  head_req;
    lsu_req_t                  req_q;

    // Valid lanes pack densely from tail in ascending lane order.
    always_comb begin
        push     = disp_valid_i & {DISP_WIDTH{disp_ready_o}};
        push_cnt = '0;
        pos      = tail;
        for (int l = 0; l < DISP_WIDTH; l++) begin
            lane_slot[l] = pos;
            lane_op[l]   = '{wmem:    disp_wmem_i[l],
                             msigned: disp_msigned_i[l],
                             msize:   disp_msize_i[l],
                             imm:     disp_imm_i[l]};
            if (push[l]) begin
                pos      = pos + IDX_W'(1);
                push_cnt = push_cnt + CNT_W'(1);
            end
        end
    end

    always_comb begin
        for (int s = 0; s < IQ_SIZE; s++) begin
            slot_init[s] = 1'b0;
            slot_lane[s] = '0;
            for (int l = 0; l < DISP_WIDTH; l++) begin
                if (push[l] && (lane_slot[l] == IDX_W'(s))) begin
                    slot_init[s] = 1'b1;
                    slot_lane[s] = LANE_W'(l);
                end
            end
        end
    end

    for (genvar s = 0; s < IQ_SIZE; s++) begin : g_slot
        lsu_iq_slot #(
            .CDB_COUNT(CDB_COUNT),
            .ROB_ID_W (ROB_ID_W)
        ) u_slot (
            .clk           (clk),
            .rst           (rst),
            .flush         (flush),
            .init          (slot_init[s]),
            .init_op       (lane_op[slot_lane[s]]),
            .init_rob_id   (disp_rob_id_i[slot_lane[s]]),
            .init_src_valid(disp_src_valid_i[slot_lane[s]]),
            .init_src_tag  (disp_src_tag_i[slot_lane[s]]),
            .init_src_data (disp_src_data_i[slot_lane[s]]),
            .pop           (pop && (head == IDX_W'(s))),
            .cdb_valid     (cdb_valid_i),
            .cdb_rob_id    (cdb_rob_id_i),
            .cdb_data      (cdb_data_i),
            .ready         (slot_ready[s]),
            .op            (slot_op[s]),
            .rob_id        (slot_rob[s]),
            .src_data      (slot_src[s])
        );
    end

    always_comb begin
        pop        = slot_ready[head] && (!req_valid_o || req_ready_i);
        head_req   = build_req(slot_op[head], slot_src[head][1],
                               slot_src[head][0]);
        count_next = count + push_cnt - CNT_W'(pop);
        free       = IQ_SIZE - int'(count_next);
        ready_next = free >= DISP_WIDTH;
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            head         <= '0;
            tail         <= '0;
            count        <= '0;
            disp_ready_o <= 1'b1;
            req_valid_o  <= 1'b0;
            req_rob_id_o <= '0;
            req_q        <= '0;
        end else begin
            head         <= head + IDX_W'(pop);
            tail         <= tail + IDX_W'(push_cnt);
            count        <= count_next;
            disp_ready_o <= ready_next;
            if (pop) begin
                req_valid_o  <= 1'b1;
                req_rob_id_o <= slot_rob[head];
                req_q        <= head_req;
            end else if (req_ready_i) begin
                req_valid_o <= 1'b0;
            end
        end
    end

    assign req_wmem_o     = req_q.wmem;
    assign req_msigned_o  = req_q.msigned;
    assign req_msize_o    = req_q.msize;
    assign req_vaddr_o    = req_q.vaddr;
    assign req_wdata_o    = req_q.wdata;
    assign req_rmask_o    = req_q.rmask;
    assign req_strb_o     = req_q.strb;
    assign req_misalign_o = req_q.misalign;
    assign occupancy_o    = count;

endmodule

// File: tb/tb_lsu_issue_queue.sv
// Bench for lsu_issue_queue: directed checks plus a queue-based model.
// Follows LSU_ISSUE_QUEUE_CDB_BYPASS_EN when defined.
module tb_lsu_issue_queue;

    localparam int IQ = 8;
    localparam int DW = 2;
    localparam int CC = 2;
    localparam int RW = 6;
`ifdef LSU_ISSUE_QUEUE_CDB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst, flush;
    logic [DW-1:0] disp_valid, disp_wmem, disp_msigned;
    logic disp_ready;
    logic [DW-1:0][1:0] disp_msize, disp_src_valid;
    logic [DW-1:0][31:0] disp_imm;
    logic [DW-1:0][RW-1:0] disp_rob;
    logic [DW-1:0][1:0][RW-1:0] disp_src_tag;
    logic [DW-1:0][1:0][31:0] disp_src_data;
    logic [CC-1:0] cdb_valid;
    logic [CC-1:0][RW-1:0] cdb_rob;
    logic [CC-1:0][31:0] cdb_data;
    logic req_valid, req_ready, req_wmem, req_msigned, req_misalign;
    logic [RW-1:0] req_rob;
    logic [1:0] req_msize;
    logic [31:0] req_vaddr, req_wdata;
    logic [3:0] req_rmask, req_strb;
    logic [3:0] occupancy;

    always #5 clk = ~clk;

    lsu_issue_queue #(.IQ_SIZE(IQ), .DISP_WIDTH(DW), .CDB_COUNT(CC),
                      .ROB_ID_W(RW)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .disp_valid_i(disp_valid), .disp_ready_o(disp_ready),
        .disp_wmem_i(disp_wmem), .disp_msigned_i(disp_msigned),
        .disp_msize_i(disp_msize), .disp_imm_i(disp_imm),
        .disp_rob_id_i(disp_rob), .disp_src_valid_i(disp_src_valid),
        .disp_src_tag_i(disp_src_tag), .disp_src_data_i(disp_src_data),
        .cdb_valid_i(cdb_valid), .cdb_rob_id_i(cdb_rob),
        .cdb_data_i(cdb_data),
        .req_valid_o(req_valid), .req_ready_i(req_ready),
        .req_rob_id_o(req_rob), .req_wmem_o(req_wmem),
        .req_msigned_o(req_msigned), .req_msize_o(req_msize),
        .req_vaddr_o(req_vaddr), .req_wdata_o(req_wdata),
        .req_rmask_o(req_rmask), .req_strb_o(req_strb),
        .req_misalign_o(req_misalign), .occupancy_o(occupancy)
    );

    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string n, input logic [31:0] got,
                       input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", n, got, exp);
        end
    endtask

    // Reference model: an ordered list of pending ops plus the output slot.
    typedef struct {
        bit wmem, msigned;
        bit [1:0] msize;
        bit [31:0] imm;
        bit [RW-1:0] rob;
        bit [1:0] sv;
        bit [1:0][RW-1:0] st;
        bit [1:0][31:0] sd;
    } ent_t;

    ent_t mq[$];
    bit m_rv, m_wmem, m_ms, m_mis, m_dready;
    bit [RW-1:0] m_rob;
    bit [1:0] m_msize;
    bit [31:0] m_vaddr, m_wdata;
    bit [3:0] m_rmask, m_strb;

    function automatic bit cdb_lookup(input bit [RW-1:0] tag,
                                      output bit [31:0] d);
        d = 0;
        for (int c = 0; c < CC; c++)
            if (cdb_valid[c] && cdb_rob[c] == tag) begin
                d = cdb_data[c];
                return 1'b1;
            end
        return 1'b0;
    endfunction

    task automatic model_step();
        ent_t h, e;
        bit ok0, ok1, elig;
        bit [31:0] b, s, cd, a;
        bit [3:0] mask;
        if (rst || flush) begin
            mq.delete();
            m_rv = 0; m_rob = 0; m_wmem = 0; m_ms = 0; m_msize = 0;
            m_vaddr = 0; m_wdata = 0; m_rmask = 0; m_strb = 0; m_mis = 0;
            m_dready = 1;
            return;
        end
        elig = 0;
        if (mq.size() > 0) begin
            h = mq[0];
            ok1 = h.sv[1]; b = h.sd[1];
            ok0 = h.sv[0]; s = h.sd[0];
            if (BYP && !ok1 && cdb_lookup(h.st[1], cd)) begin ok1 = 1; b = cd; end
            if (BYP && !ok0 && cdb_lookup(h.st[0], cd)) begin ok0 = 1; s = cd; end
            elig = ok1 && (!h.wmem || ok0);
        end
        if (elig && (!m_rv || req_ready)) begin
            void'(mq.pop_front());
            a = b + h.imm;
            case (h.msize)
                2'd0: mask = 4'b0001 << a[1:0];
                2'd1: mask = a[1] ? 4'b1100 : 4'b0011;
                default: mask = 4'b1111;
            endcase
            m_rv = 1; m_rob = h.rob; m_wmem = h.wmem; m_ms = h.msigned;
            m_msize = h.msize; m_vaddr = a;
            m_wdata = h.wmem ? s : 0;
            m_rmask = h.wmem ? 4'b0 : mask;
            m_strb  = h.wmem ? mask : 4'b0;
            m_mis = (h.msize == 1 && a[0]) || (h.msize == 2 && a[1:0] != 0);
        end else if (req_ready) begin
            m_rv = 0;
        end
        foreach (mq[i])
            for (int k = 0; k < 2; k++)
                if (!mq[i].sv[k] && cdb_lookup(mq[i].st[k], cd)) begin
                    mq[i].sv[k] = 1; mq[i].sd[k] = cd;
                end
        if (m_dready)
            for (int l = 0; l < DW; l++)
                if (disp_valid[l]) begin
                    e.wmem = disp_wmem[l]; e.msigned = disp_msigned[l];
                    e.msize = disp_msize[l]; e.imm = disp_imm[l];
                    e.rob = disp_rob[l]; e.sv = disp_src_valid[l];
                    e.st = disp_src_tag[l]; e.sd = disp_src_data[l];
                    for (int k = 0; k < 2; k++)
                        if (!e.sv[k] && cdb_lookup(e.st[k], cd)) begin
                            e.sv[k] = 1; e.sd[k] = cd;
                        end
                    mq.push_back(e);
                end
        m_dready = (IQ - mq.size()) >= DW;
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    initial begin
        @(posedge clk);
        forever begin
            @(negedge clk);
            chk("m_disp_ready", disp_ready, m_dready);
            chk("m_occupancy", occupancy, mq.size());
            chk("m_req_valid", req_valid, m_rv);
            if (m_rv) begin
                chk("m_rob", req_rob, m_rob);
                chk("m_kind", {req_wmem, req_msigned, req_msize},
                    {m_wmem, m_ms, m_msize});
                chk("m_vaddr", req_vaddr, m_vaddr);
                chk("m_wdata", req_wdata, m_wdata);
                chk("m_masks", {req_rmask, req_strb}, {m_rmask, m_strb});
                chk("m_misalign", req_misalign, m_mis);
            end
        end
    end

    task automatic idle();
        disp_valid = 0; cdb_valid = 0; flush = 0;
    endtask

    task automatic lane(input int l, input bit wm, input bit [1:0] sz,
                        input bit [31:0] imm, input bit [RW-1:0] rob,
                        input bit [1:0] sv, input bit [RW-1:0] t0,
                        input bit [RW-1:0] t1, input bit [31:0] d0,
                        input bit [31:0] d1);
        disp_valid[l] = 1; disp_wmem[l] = wm; disp_msigned[l] = 0;
        disp_msize[l] = sz; disp_imm[l] = imm; disp_rob[l] = rob;
        disp_src_valid[l] = sv;
        disp_src_tag[l][0] = t0; disp_src_tag[l][1] = t1;
        disp_src_data[l][0] = d0; disp_src_data[l][1] = d1;
    endtask

    logic [RW-1:0] seen[$];

    initial begin
        rst = 1; req_ready = 1;
        disp_wmem = 0; disp_msigned = 0; disp_msize = 0; disp_imm = 0;
        disp_rob = 0; disp_src_valid = 0; disp_src_tag = 0;
        disp_src_data = 0; cdb_rob = 0; cdb_data = 0;
        idle();
        repeat (3) @(negedge clk);
        chk("reset_req_valid", req_valid, 0);
        chk("reset_occ", occupancy, 0);
        chk("reset_disp_ready", disp_ready, 1);
        chk("reset_vaddr", req_vaddr, 0);
        rst = 0;

        // Word load, operands ready: visible two cycles later.
        lane(0, 0, 2, 32'h4, 1, 2'b11, 0, 0, 0, 32'h1000);
        @(negedge clk); idle();
        chk("t1_not_yet", req_valid, 0);
        @(negedge clk);
        chk("t1_valid", req_valid, 1);
        chk("t1_vaddr", req_vaddr, 32'h1004);
        chk("t1_rmask", req_rmask, 4'hF);
        chk("t1_strb", req_strb, 4'h0);

        // Half store waiting on data tag 5.
        @(negedge clk);
        req_ready = 0;
        lane(0, 1, 1, 0, 2, 2'b10, 5, 0, 0, 32'h2002);
        @(negedge clk); idle();
        chk("t2_wait", req_valid, 0);
        cdb_valid = 2'b01; cdb_rob[0] = 5; cdb_data[0] = 32'hABCD;
        @(negedge clk); idle();
        chk("t2_m1", req_valid, BYP);
        @(negedge clk);
        chk("t2_m2", req_valid, 1);
        chk("t2_strb", req_strb, 4'b1100);
        chk("t2_wdata", req_wdata, 32'hABCD);
        chk("t2_misalign", req_misalign, 0);
        req_ready = 1;
        @(negedge clk);

        // Misaligned word load.
        lane(0, 0, 2, 32'h1, 3, 2'b11, 0, 0, 0, 32'h3000);
        @(negedge clk); idle();
        @(negedge clk);
        chk("t3_misalign", req_misalign, 1);
        chk("t3_rmask", req_rmask, 4'hF);
        @(negedge clk);

        // Fill with a blocked head, then overdrive while full.
        req_ready = 0;
        for (int k = 0; k < 6; k++) begin
            lane(0, 0, 2, 0, RW'(16 + 2 * k), (k == 0) ? 2'b00 : 2'b11,
                 0, 40, 0, 32'h100);
            lane(1, 0, 2, 0, RW'(17 + 2 * k), 2'b11, 0, 0, 0, 32'h200);
            @(negedge clk);
        end
        idle();
        chk("fill_occ", occupancy, 8);
        chk("fill_ready", disp_ready, 0);
        chk("fill_noreq", req_valid, 0);
        cdb_valid = 2'b10; cdb_rob[1] = 40; cdb_data[1] = 32'h100;
        req_ready = 1;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk); idle();
            if (req_valid && req_ready) seen.push_back(req_rob);
        end
        chk("drain_count", seen.size(), 8);
        foreach (seen[i]) chk("drain_order", seen[i], 16 + i);

        // Flush with a pending request and five queued entries.
        req_ready = 0;
        for (int k = 0; k < 3; k++) begin
            lane(0, 0, 2, 0, RW'(32 + 2 * k), 2'b11, 0, 0, 0, 0);
            lane(1, 0, 2, 0, RW'(33 + 2 * k), 2'b11, 0, 0, 0, 0);
            @(negedge clk);
        end
        idle();
        chk("pre_flush_valid", req_valid, 1);
        chk("pre_flush_occ", occupancy, 5);
        flush = 1;
        @(negedge clk); flush = 0;
        chk("flush_valid", req_valid, 0);
        chk("flush_occ", occupancy, 0);
        chk("flush_ready", disp_ready, 1);

        // Random traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            flush = ($urandom_range(99) == 0);
            req_ready = ($urandom_range(2) != 0);
            disp_valid = ($urandom_range(3) == 0) ? '0 : DW'($urandom);
            for (int l = 0; l < DW; l++) begin
                disp_wmem[l] = $urandom_range(1);
                disp_msigned[l] = $urandom_range(1);
                disp_msize[l] = $urandom_range(2);
                disp_imm[l] = $urandom_range(1) ? $urandom : $urandom_range(7);
                disp_rob[l] = $urandom;
                disp_src_valid[l] = $urandom;
                for (int k = 0; k < 2; k++) begin
                    disp_src_tag[l][k] = $urandom_range(7);
                    disp_src_data[l][k] = $urandom;
                end
            end
            for (int i = 0; i < CC; i++) begin
                cdb_valid[i] = $urandom_range(1);
                cdb_rob[i] = $urandom_range(7);
                cdb_data[i] = $urandom;
            end
            @(negedge clk);
        end
        idle();
        req_ready = 1;
        repeat (4) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
